// File: rtl/render_pkg.sv
// Shared frame-buffer geometry and render sequencer state encoding.
package render_pkg;

    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int FB_ADDR_W = 15;
    localparam int COLOR_W   = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_RUN    = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } render_state_t;

endpackage

// File: rtl/m_render_wr_mux.sv
// Registered N:1 mux from the active render stage onto the frame-buffer write port.
module m_render_wr_mux
    import render_pkg::*;
#(
    parameter int N_STAGES = 3,
    parameter int IDX_W    = 2
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          run,
    input  logic [IDX_W-1:0]              idx,
    input  logic [N_STAGES-1:0]           stage_wren,
    input  logic [N_STAGES*FB_ADDR_W-1:0] stage_addr,
    input  logic [N_STAGES*COLOR_W-1:0]   stage_data,
    output logic                          fb_wren,
    output logic [FB_ADDR_W-1:0]          fb_addr,
    output logic [COLOR_W-1:0]            fb_data
);

    logic                 fb_wren_q, fb_wren_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [COLOR_W-1:0]   fb_data_q, fb_data_d;

    // Address and data only move on an accepted write so the port holds its last value.
    always_comb begin
        fb_wren_d = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        for (int i = 0; i < N_STAGES; i++) begin
            if (run && (idx == IDX_W'(i)) && stage_wren[i]) begin
                fb_wren_d = 1'b1;
                fb_addr_d = stage_addr[FB_ADDR_W*i +: FB_ADDR_W];
                fb_data_d = stage_data[COLOR_W*i +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fb_wren_q <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            fb_wren_q <= fb_wren_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
        end
    end

    assign fb_wren = fb_wren_q;
    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;

endmodule

// File: rtl/m_render_sequencer.sv
// Per-frame render stage scheduler with frame-buffer write muxing.
// Optional stage watchdog enabled by defining RENDER_WATCHDOG_EN.
module m_render_sequencer
    import render_pkg::*;
#(
    parameter int N_STAGES        = 3,
    parameter int WATCHDOG_CYCLES = 32768
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          frame_tick,
    input  logic [N_STAGES-1:0]           stage_skip,
    output logic [N_STAGES-1:0]           stage_enable,
    input  logic [N_STAGES-1:0]           stage_finished,
    input  logic [N_STAGES-1:0]           stage_wren,
    input  logic [N_STAGES*FB_ADDR_W-1:0] stage_addr,
    input  logic [N_STAGES*COLOR_W-1:0]   stage_data,
    output logic                          fb_wren,
    output logic [FB_ADDR_W-1:0]          fb_addr,
    output logic [COLOR_W-1:0]            fb_data,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun,
    output logic                          timeout_err
);

    localparam int IDX_W = $clog2(N_STAGES + 1);

    render_state_t        state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_STAGES-1:0]  skip_q, skip_d;
    logic [N_STAGES-1:0]  stage_enable_q, stage_enable_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic                 cur_skip, cur_finished, wd_expired;

    always_comb begin
        cur_skip     = 1'b0;
        cur_finished = 1'b0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_skip     = skip_q[i];
                cur_finished = stage_finished[i];
            end
        end
    end

`ifdef RENDER_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(WATCHDOG_CYCLES - 1);

    logic [15:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ST_SELECT) begin
            wd_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign wd_expired = (state_q == ST_RUN) && (wd_cnt_q == WD_LAST);
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        skip_d       = skip_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        timeout_d    = timeout_q;
        overrun_d    = overrun_q | (frame_tick && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    skip_d  = stage_skip;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (idx_q == IDX_W'(N_STAGES)) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                end else if (cur_skip) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cur_finished || wd_expired) begin
                    state_d = ST_GAP;
                    if (!cur_finished) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_SELECT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        for (int i = 0; i < N_STAGES; i++) begin
            stage_enable_d[i] = (state_d == ST_RUN) && (idx_d == IDX_W'(i));
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            skip_q         <= '0;
            stage_enable_q <= '0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            skip_q         <= skip_d;
            stage_enable_q <= stage_enable_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
        end
    end

    // Writes are qualified by the current state, so a write in the finishing cycle still lands.
    m_render_wr_mux #(
        .N_STAGES (N_STAGES),
        .IDX_W    (IDX_W)
    ) u_wr_mux (
        .clock      (clock),
        .resetn     (resetn),
        .run        (state_q == ST_RUN),
        .idx        (idx_q),
        .stage_wren (stage_wren),
        .stage_addr (stage_addr),
        .stage_data (stage_data),
        .fb_wren    (fb_wren),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data)
    );

    assign stage_enable = stage_enable_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_m_render_sequencer.sv
// Randomized self-checking bench for m_render_sequencer with stub render stages.
module tb_m_render_sequencer;

`ifdef RENDER_WATCHDOG_EN
    localparam int WD = 16;
`else
    localparam int WD = 32768;
`endif

    logic          clock;
    logic          resetn;
    logic          frame_tick;
    logic [2:0]    stage_skip;
    logic [2:0]    stage_enable;
    logic [2:0]    stage_finished;
    logic [2:0]    stage_wren;
    logic [44:0]   stage_addr;
    logic [35:0]   stage_data;
    logic          fb_wren;
    logic [14:0]   fb_addr;
    logic [11:0]   fb_data;
    logic          busy;
    logic          frame_done;
    logic          overrun;
    logic          timeout_err;

    m_render_sequencer #(
        .N_STAGES        (3),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .frame_tick     (frame_tick),
        .stage_skip     (stage_skip),
        .stage_enable   (stage_enable),
        .stage_finished (stage_finished),
        .stage_wren     (stage_wren),
        .stage_addr     (stage_addr),
        .stage_data     (stage_data),
        .fb_wren        (fb_wren),
        .fb_addr        (fb_addr),
        .fb_data        (fb_data),
        .busy           (busy),
        .frame_done     (frame_done),
        .overrun        (overrun),
        .timeout_err    (timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Stub stages: raise finished after K enabled cycles, drop it once enable falls.
    int stub_k   [3];
    int stub_cnt [3];

    always @(posedge clock or negedge resetn) begin
        for (int i = 0; i < 3; i++) begin
            if (!resetn || !stage_enable[i]) stub_cnt[i] <= 0;
            else                             stub_cnt[i] <= stub_cnt[i] + 1;
        end
    end

    always_comb begin
        stage_finished = 3'b000;
        for (int i = 0; i < 3; i++) begin
            stage_finished[i] = stage_enable[i] && (stub_cnt[i] >= stub_k[i]);
        end
    end

    int total;
    int bad;

    logic [2:0]  drv_wren;
    logic [14:0] drv_addr [3];
    logic [11:0] drv_data [3];
    bit          directed;

    logic [14:0] exp_addr;
    logic [11:0] exp_data;

    int seq_code, len_code, first_en, done_cyc, done_pulses;
    int busy_bad, gap_bad, onehot_bad, fb_errs, timed_out;
    bit saw_directed;
    logic [28:0] fb_first_act, fb_first_exp;

    task automatic drive_stages();
        for (int i = 0; i < 3; i++) begin
            drv_wren[i] = 1'($urandom_range(0, 1));
            drv_addr[i] = 15'($urandom_range(0, 19199));
            drv_data[i] = 12'($urandom);
        end
        if (directed) begin
            drv_wren[1] = 1'b1;
            drv_addr[1] = 15'd19199;
            drv_data[1] = 12'hF00;
        end
        for (int i = 0; i < 3; i++) begin
            stage_wren[i]           = drv_wren[i];
            stage_addr[15*i +: 15]  = drv_addr[i];
            stage_data[12*i +: 12]  = drv_data[i];
        end
    endtask

    function automatic int stage_of(input logic [2:0] en);
        int s = -1;
        for (int i = 0; i < 3; i++) if (en[i]) s = i;
        return s;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Frame model: non-skipped stages run in index order, each enabled for
    // min(K+1, WD) cycles, with SELECT+GAP overhead around each run.
    function automatic int model_seq(input logic [2:0] skip);
        int c = 0;
        for (int i = 0; i < 3; i++) if (!skip[i]) c = c * 4 + (i + 1);
        return c;
    endfunction

    function automatic int model_len(input logic [2:0] skip);
        int c = 0;
        for (int i = 0; i < 3; i++) if (!skip[i]) c = c * 64 + min_int(stub_k[i] + 1, WD);
        return c;
    endfunction

    function automatic int model_done(input logic [2:0] skip);
        int lat = 2;
        for (int i = 0; i < 3; i++) begin
            if (skip[i]) lat += 1;
            else         lat += min_int(stub_k[i] + 1, WD) + 2;
        end
        return lat;
    endfunction

    task automatic randomize_k();
        for (int i = 0; i < 3; i++) stub_k[i] = $urandom_range(1, 6);
    endtask

    task automatic run_frame(input logic [2:0] skip, input bit inject);
        logic [2:0] prev_en, en;
        bit exp_w, injected;
        int n, cur_len;
        seq_code = 0; len_code = 0; first_en = -1; done_cyc = -1; done_pulses = 0;
        busy_bad = 0; gap_bad = 0; onehot_bad = 0; fb_errs = 0; timed_out = 0;
        saw_directed = 0; injected = 0; n = 0; cur_len = 0;
        stage_skip = skip;
        frame_tick = 1'b1;
        drive_stages();
        prev_en = stage_enable;
        forever begin
            exp_w = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (prev_en[i] && drv_wren[i]) begin
                    exp_w = 1'b1; exp_addr = drv_addr[i]; exp_data = drv_data[i];
                end
            end
            @(posedge clock); #1;
            n++;
            frame_tick = 1'b0;
            if ({fb_wren, fb_addr, fb_data} !== {exp_w, exp_addr, exp_data}) begin
                if (fb_errs == 0) begin
                    fb_first_act = {fb_wren, fb_addr, fb_data};
                    fb_first_exp = {exp_w, exp_addr, exp_data};
                end
                fb_errs++;
            end
            if (fb_wren && fb_addr == 15'd19199 && fb_data == 12'hF00) saw_directed = 1;
            en = stage_enable;
            if ($countones(en) > 1) onehot_bad++;
            if (en != 3'b000 && prev_en != 3'b000 && en != prev_en) gap_bad++;
            if (en != 3'b000 && prev_en == 3'b000) begin
                seq_code = seq_code * 4 + stage_of(en) + 1;
                if (first_en < 0) first_en = n;
                cur_len = 1;
            end else if (en != 3'b000) begin
                cur_len++;
            end
            if (en == 3'b000 && prev_en != 3'b000) len_code = len_code * 64 + cur_len;
            if (frame_done) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = n;
                if (busy !== 1'b0) busy_bad++;
            end else if (done_cyc < 0) begin
                if (busy !== 1'b1) busy_bad++;
            end else if (busy !== 1'b0) begin
                busy_bad++;
            end
            if (done_cyc >= 0 && n >= done_cyc + 3) break;
            if (n > 3000) begin timed_out = 1; break; end
            prev_en = en;
            drive_stages();
            if (inject && !injected && en == 3'b010) begin
                frame_tick = 1'b1;
                injected = 1;
            end
        end
    endtask

    task automatic check_frame(input string name, input logic [2:0] skip);
        total++;
        if (timed_out !== 0) begin bad++; $display("FAIL %s timeout: frame_done not seen in 3000 cycles", name); end
        total++;
        if (seq_code !== model_seq(skip)) begin bad++; $display("FAIL %s order: got code %0d want %0d", name, seq_code, model_seq(skip)); end
        total++;
        if (len_code !== model_len(skip)) begin bad++; $display("FAIL %s enable_len: got code %0d want %0d", name, len_code, model_len(skip)); end
        total++;
        if (done_cyc !== model_done(skip)) begin bad++; $display("FAIL %s done_latency: got %0d want %0d", name, done_cyc, model_done(skip)); end
        total++;
        if (done_pulses !== 1) begin bad++; $display("FAIL %s done_pulses: got %0d want 1", name, done_pulses); end
        total++;
        if ({busy_bad, gap_bad, onehot_bad} !== {32'd0, 32'd0, 32'd0}) begin
            bad++; $display("FAIL %s busy/gap/onehot errors: got %0d/%0d/%0d want 0/0/0", name, busy_bad, gap_bad, onehot_bad);
        end
        total++;
        if (fb_errs !== 0) begin
            bad++; $display("FAIL %s fb_port: %0d errors, first got %h want %h", name, fb_errs, fb_first_act, fb_first_exp);
        end
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        #20;
        @(posedge clock); #1;
        resetn = 1'b1;
        exp_addr = '0;
        exp_data = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({stage_enable, fb_wren, fb_addr, fb_data, busy, frame_done, overrun, timeout_err} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs: got en=%b wr=%b a=%0d d=%h busy=%b done=%b ovr=%b to=%b want all 0",
                     stage_enable, fb_wren, fb_addr, fb_data, busy, frame_done, overrun, timeout_err);
        end
    endtask

    task automatic test_sequence();
        for (int f = 0; f < 3; f++) begin
            randomize_k();
            run_frame(3'b000, 0);
            check_frame("sequence", 3'b000);
            total++;
            if (first_en !== 2) begin bad++; $display("FAIL first_enable_latency: got %0d want 2", first_en); end
        end
        total++;
        if ({overrun, timeout_err} !== 2'b00) begin bad++; $display("FAIL sticky_clear: got ovr=%b to=%b want 0 0", overrun, timeout_err); end
    endtask

    task automatic test_write_mux();
        directed = 1;
        randomize_k();
        run_frame(3'b000, 0);
        directed = 0;
        check_frame("write_mux", 3'b000);
        total++;
        if (saw_directed !== 1) begin bad++; $display("FAIL write_19199_F00: got seen=%0d want 1", saw_directed); end
    endtask

    task automatic test_skip();
        randomize_k();
        run_frame(3'b010, 0);
        check_frame("skip_010", 3'b010);
        randomize_k();
        run_frame(3'b111, 0);
        check_frame("skip_111", 3'b111);
        total++;
        if (done_cyc !== 5) begin bad++; $display("FAIL all_skip_latency: got %0d want 5", done_cyc); end
        for (int f = 0; f < 4; f++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            randomize_k();
            run_frame(s, 0);
            check_frame("skip_random", s);
        end
    endtask

    task automatic test_overrun();
        randomize_k();
        run_frame(3'b000, 1);
        check_frame("overrun_frame", 3'b000);
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", overrun); end
        randomize_k();
        run_frame(3'b000, 0);
        check_frame("after_overrun", 3'b000);
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        randomize_k();
        stub_k[1] = 6;
        stage_skip = 3'b000;
        frame_tick = 1'b1;
        drive_stages();
        stage_wren = 3'b111;
        while (stage_enable !== 3'b010 && n < 200) begin
            @(posedge clock); #1;
            frame_tick = 1'b0;
            n++;
        end
        total++;
        if (stage_enable !== 3'b010) begin bad++; $display("FAIL reset_mid_reach: got en=%b want 010", stage_enable); end
        @(posedge clock); #1;
        resetn = 1'b0;
        #1;
        total++;
        if ({stage_enable, fb_wren, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_mid_drop: got en=%b wr=%b busy=%b want 000 0 0", stage_enable, fb_wren, busy);
        end
        @(posedge clock); #1;
        resetn = 1'b1;
        exp_addr = '0;
        exp_data = '0;
        randomize_k();
        run_frame(3'b000, 0);
        check_frame("after_reset_mid", 3'b000);
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL reset_clears_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_watchdog();
`ifdef RENDER_WATCHDOG_EN
        randomize_k();
        stub_k[0] = 100000;
        run_frame(3'b000, 0);
        check_frame("watchdog", 3'b000);
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_set: got %b want 1", timeout_err); end
`else
        randomize_k();
        stub_k[1] = 40;
        run_frame(3'b000, 0);
        check_frame("long_stage", 3'b000);
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_err_tied: got %b want 0", timeout_err); end
`endif
    endtask

    initial begin
        total = 0;
        bad = 0;
        directed = 0;
        frame_tick = 1'b0;
        stage_skip = 3'b000;
        stage_wren = 3'b000;
        stage_addr = '0;
        stage_data = '0;
        for (int i = 0; i < 3; i++) stub_k[i] = 1;
        exp_addr = '0;
        exp_data = '0;
        test_reset();
        test_sequence();
        test_write_mux();
        test_skip();
        test_watchdog();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
